// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_pkg
//  Description : Shared types and helpers for the phy-final transmit path.
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_pkg;

    localparam logic [7:0] IDLE_CHAR_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        SYNC     = 2'd1,
        ACTIVE   = 2'd2
    } tx_state_t;

    // Width of a lane index; never narrower than one bit.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_tx_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority picker. Searches req
//                starting at index 'start' with wrap; the first set request
//                wins. Shared with the receive-side distributor.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import phy_pkg::*;
#(
    parameter int N = 4,
    parameter int W = lane_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    // Walk the rotation backwards so the earliest position in the search
    // order is the last to write, and therefore the one that wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/phy_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_scheduler
//  Description : Shares one byte-wide serializer between NUM_LANES requesters.
//                Emits SYNC_COUNT idle words after enable, then grants lanes
//                round-robin with bursts of at most MAX_BURST bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_scheduler
    import phy_pkg::*;
#(
    parameter  int         NUM_LANES  = 4,
    parameter  int         SYNC_COUNT = 4,
    parameter  int         MAX_BURST  = 2,
    parameter  logic [7:0] IDLE_CHAR  = IDLE_CHAR_DEFAULT,
    localparam int         LW         = lane_w(NUM_LANES)
) (
    input  logic                   clk_f,
    input  logic                   reset,
    input  logic                   link_en,
    input  logic [8*NUM_LANES-1:0] data_in,
    input  logic [NUM_LANES-1:0]   valid_in,
    output logic [NUM_LANES-1:0]   pop,
    output logic [7:0]             data_out,
    output logic                   valid_out,
    output logic [LW-1:0]          lane_id,
    output logic                   sync_done
);

    localparam logic [7:0]    SYNC_LAST = 8'(SYNC_COUNT - 1);
    localparam logic [3:0]    BURST_MAX = 4'(MAX_BURST);
    localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [LW-1:0] owner;
    logic [3:0]    burst_cnt;
    logic [7:0]    sync_cnt;

    logic [LW-1:0]        start_idx;
    logic [NUM_LANES-1:0] pick_grant;
    logic [LW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 keep;
    logic                 sel_valid;
    logic [LW-1:0]        sel;
    logic [7:0]           lane_byte [NUM_LANES];

    // burst_cnt==0 means no lane currently holds a grant, so after reset or
    // an idle cycle the search restarts at owner+1 instead of re-keeping owner.
    assign keep      = (state == ACTIVE) && link_en && valid_in[owner]
                       && (burst_cnt != 4'd0) && (burst_cnt < BURST_MAX);
    assign start_idx = (owner == LAST_LANE) ? '0 : owner + 1'b1;
    assign sel_valid = (state == ACTIVE) && link_en && (keep || pick_any);
    assign sel       = keep ? owner : pick_idx;

    rr_pick #(
        .N (NUM_LANES),
        .W (LW)
    ) u_rr_pick (
        .req   (valid_in),
        .start (start_idx),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            assign lane_byte[i] = data_in[8*i +: 8];
            assign pop[i]       = sel_valid && (keep ? (owner == LW'(i)) : pick_grant[i]);
        end
    endgenerate

    // State register.
    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state <= DISABLED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: link_en low always falls back to DISABLED.
    always_comb begin
        state_nxt = state;
        case (state)
            DISABLED: if (link_en) state_nxt = SYNC;
            SYNC: begin
                if (!link_en)                  state_nxt = DISABLED;
                else if (sync_cnt == SYNC_LAST) state_nxt = ACTIVE;
            end
            ACTIVE:   if (!link_en) state_nxt = DISABLED;
            default:  state_nxt = DISABLED;
        endcase
    end

    // Output byte register, grant bookkeeping and sync counter.
    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            owner     <= LAST_LANE;
            burst_cnt <= 4'd0;
            sync_cnt  <= 8'd0;
            data_out  <= IDLE_CHAR;
            valid_out <= 1'b0;
            lane_id   <= '0;
            sync_done <= 1'b0;
        end else begin
            sync_cnt  <= (state == SYNC) ? sync_cnt + 8'd1 : 8'd0;
            sync_done <= (state_nxt == ACTIVE);
            if (sel_valid) begin
                data_out  <= lane_byte[sel];
                valid_out <= 1'b1;
                lane_id   <= sel;
                owner     <= sel;
                burst_cnt <= keep ? burst_cnt + 4'd1 : 4'd1;
            end else begin
                data_out  <= IDLE_CHAR;
                valid_out <= 1'b0;
                lane_id   <= '0;
                burst_cnt <= 4'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_tx_scheduler
//  Description : Self-checking bench for phy_tx_scheduler: directed vector
//                table, asynchronous reset sequence and randomized traffic
//                against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_tx_scheduler;

    localparam int N     = 4;
    localparam int SYNCN = 4;
    localparam int MAXB  = 2;

    logic        clk_f = 1'b0;
    logic        reset;
    logic        link_en;
    logic [31:0] data_in;
    logic [3:0]  valid_in;
    logic [3:0]  pop;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  lane_id;
    logic        sync_done;

    int checks = 0;
    int errors = 0;

    phy_tx_scheduler #(
        .NUM_LANES  (N),
        .SYNC_COUNT (SYNCN),
        .MAX_BURST  (MAXB),
        .IDLE_CHAR  (8'hBC)
    ) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .link_en   (link_en),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .pop       (pop),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_id   (lane_id),
        .sync_done (sync_done)
    );

    always #5 clk_f = ~clk_f;

    typedef struct {
        logic        link;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  epop;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  el;
        logic        es;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(logic l, logic [3:0] v, logic [31:0] d, logic [3:0] p,
                                 logic ev, logic [7:0] ed, logic [1:0] el, logic es);
        vec_t r;
        r.link = l; r.valid = v; r.data = d; r.epop = p;
        r.ev = ev; r.ed = ed; r.el = el; r.es = es;
        return r;
    endfunction

    task automatic check_pop(input string name, input logic [3:0] exp_pop);
        checks++;
        if (pop !== exp_pop) begin
            errors++;
            $display("FAIL %s pop: got %b want %b (t=%0t)", name, pop, exp_pop, $time);
        end
    endtask

    task automatic check_out(input string name, input logic ev, input logic [7:0] ed,
                             input logic [1:0] el, input logic es);
        checks++;
        if (valid_out !== ev || data_out !== ed || lane_id !== el || sync_done !== es) begin
            errors++;
            $display("FAIL %s out: got v=%b d=%h l=%0d s=%b want v=%b d=%h l=%0d s=%b (t=%0t)",
                     name, valid_out, data_out, lane_id, sync_done, ev, ed, el, es, $time);
        end
    endtask

    // One clock: drive at negedge, check combinational pop, then registered outputs.
    task automatic step(input string name, input vec_t r);
        @(negedge clk_f);
        link_en  = r.link;
        valid_in = r.valid;
        data_in  = r.data;
        #1;
        check_pop(name, r.epop);
        @(posedge clk_f);
        #1;
        check_out(name, r.ev, r.ed, r.el, r.es);
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int PH_OFF = 0, PH_WARM = 1, PH_RUN = 2;
    int         m_phase, m_warm_left, m_owner, m_run;
    logic       m_v, m_s;
    logic [7:0] m_d;
    logic [1:0] m_l;

    task automatic model_reset();
        m_phase = PH_OFF; m_warm_left = 0; m_owner = N - 1; m_run = 0;
        m_v = 1'b0; m_d = 8'hBC; m_l = 2'd0; m_s = 1'b0;
    endtask

    // Returns the lane granted this cycle, or -1; whether it continues a burst.
    function automatic int model_pick(input logic l, input logic [3:0] v, output logic cont);
        int s;
        s    = -1;
        cont = 1'b0;
        if (m_phase == PH_RUN && l) begin
            if (m_run > 0 && m_run < MAXB && v[m_owner]) begin
                s    = m_owner;
                cont = 1'b1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (s < 0 && v[(m_owner + k) % N]) s = (m_owner + k) % N;
                end
            end
        end
        return s;
    endfunction

    task automatic model_clock(input logic l, input logic [31:0] d, input int s, input logic cont);
        if (s >= 0) begin
            m_v = 1'b1; m_d = d[8*s +: 8]; m_l = 2'(s);
            m_run = cont ? m_run + 1 : 1;
            m_owner = s;
        end else begin
            m_v = 1'b0; m_d = 8'hBC; m_l = 2'd0; m_run = 0;
        end
        if (!l) begin
            m_phase = PH_OFF;
        end else if (m_phase == PH_OFF) begin
            m_phase = PH_WARM; m_warm_left = SYNCN;
        end else if (m_phase == PH_WARM) begin
            m_warm_left--;
            if (m_warm_left == 0) m_phase = PH_RUN;
        end
        m_s = (m_phase == PH_RUN);
    endtask

    localparam logic [31:0] ALL = 32'h13121110;

    initial begin
        vec_t r;
        logic [31:0] d;

        // Directed table: sync, round-robin, drop mid-burst, idle, sole lane, link drop.
        tbl.push_back(row(1, 4'hF, ALL, 4'h0, 0, 8'hBC, 0, 0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(row(1, 4'hF, ALL, 4'h0, 0, 8'hBC, 0, (k == 4)));
        tbl.push_back(row(1, 4'hF, ALL, 4'h1, 1, 8'h10, 0, 1));
        tbl.push_back(row(1, 4'hF, ALL, 4'h1, 1, 8'h10, 0, 1));
        tbl.push_back(row(1, 4'hF, ALL, 4'h2, 1, 8'h11, 1, 1));
        tbl.push_back(row(1, 4'hF, ALL, 4'h2, 1, 8'h11, 1, 1));
        tbl.push_back(row(1, 4'hF, ALL, 4'h4, 1, 8'h12, 2, 1));
        tbl.push_back(row(1, 4'hF, ALL, 4'h4, 1, 8'h12, 2, 1));
        tbl.push_back(row(1, 4'hF, ALL, 4'h8, 1, 8'h13, 3, 1));
        tbl.push_back(row(1, 4'hF, ALL, 4'h8, 1, 8'h13, 3, 1));
        tbl.push_back(row(1, 4'hF, ALL, 4'h1, 1, 8'h10, 0, 1));
        tbl.push_back(row(1, 4'hF, ALL, 4'h1, 1, 8'h10, 0, 1));
        tbl.push_back(row(1, 4'hA, 32'h23002100, 4'h2, 1, 8'h21, 1, 1));
        tbl.push_back(row(1, 4'h8, 32'h23002100, 4'h8, 1, 8'h23, 3, 1));
        tbl.push_back(row(1, 4'h0, 32'h23002100, 4'h0, 0, 8'hBC, 0, 1));
        tbl.push_back(row(1, 4'hF, 32'h33323130, 4'h1, 1, 8'h30, 0, 1));
        for (int k = 0; k < 6; k++) begin
            d = 32'h0;
            d[23:16] = 8'hA0 + 8'(k);
            tbl.push_back(row(1, 4'h4, d, 4'h4, 1, 8'hA0 + 8'(k), 2, 1));
        end
        tbl.push_back(row(1, 4'h4, 32'h00BC0000, 4'h4, 1, 8'hBC, 2, 1));
        tbl.push_back(row(0, 4'h4, 32'h00BC0000, 4'h0, 0, 8'hBC, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(row(1, 4'hF, 32'h43424140, 4'h0, 0, 8'hBC, 0, (k == 4)));
        tbl.push_back(row(1, 4'hF, 32'h43424140, 4'h8, 1, 8'h43, 3, 1));

        // Power-on reset, link off.
        reset = 1'b0; link_en = 1'b0; valid_in = 4'hF; data_in = ALL;
        repeat (3) @(posedge clk_f);
        #1;
        check_pop("por", 4'h0);
        check_out("por", 0, 8'hBC, 0, 0);
        @(negedge clk_f);
        reset = 1'b1;

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // Asynchronous reset asserted between edges while lanes are streaming.
        @(negedge clk_f);
        link_en = 1'b1; valid_in = 4'hF; data_in = 32'h53525150;
        @(posedge clk_f);
        #3;
        reset = 1'b0;
        #1;
        check_pop("async_rst", 4'h0);
        check_out("async_rst", 0, 8'hBC, 0, 0);
        @(negedge clk_f);
        link_en = 1'b0;
        @(negedge clk_f);
        reset = 1'b1;

        // Randomized traffic against the model.
        model_reset();
        for (int c = 0; c < 800; c++) begin
            int   s;
            logic cont;
            r.link  = ($urandom_range(0, 59) != 0);
            r.valid = (c % 100 < 50) ? 4'($urandom) : 4'($urandom) | 4'($urandom);
            r.data  = $urandom;
            s       = model_pick(r.link, r.valid, cont);
            r.epop  = (s >= 0) ? (4'd1 << s) : 4'd0;
            model_clock(r.link, r.data, s, cont);
            r.ev = m_v; r.ed = m_d; r.el = m_l; r.es = m_s;
            step($sformatf("rand%0d", c), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
